// File: rtl/stopwatch_pkg.sv
// Shared mode codes, LED patterns and button indices for the stopwatch control unit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_RESET = 2'd3
  } state_e;

  localparam logic [3:0] LED_RESET = 4'b1000;
  localparam logic [3:0] LED_RUN   = 4'b0100;
  localparam logic [3:0] LED_PAUSE = 4'b0010;
  localparam logic [3:0] LED_STOP  = 4'b0001;

  localparam int BTN_STOP  = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_START = 2;
  localparam int BTN_RESET = 3;

  // The prescaler advances only in these modes.
  function automatic logic is_counting(input state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_filter.sv
// One active-low button: 2-flop synchronizer, optional debounce (STOPWATCH_DEBOUNCE_EN)
// and a registered one-cycle pulse on release.
module btn_filter #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_evt
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_evt;
  logic w_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_db_cnt;
  logic          r_acc;

  // Any cycle back at the accepted level restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_acc    <= 1'b1;
    end else if (r_sync2 == r_acc) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_cnt <= '0;
      r_acc    <= r_sync2;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_level = r_acc;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b1;
      r_evt  <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_evt  <= w_level & ~r_prev;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode machine, button priority encode and 0.1 s tick prescaler.
// Optional button debounce is enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 5000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic       tick,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [3:0] led,
  output logic [1:0] state
);
  import stopwatch_pkg::*;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [3:0]    w_evt;
  state_e        r_state;
  state_e        w_next;
  logic [PW-1:0] r_presc;
  logic          r_tick;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
      .clk     (clk),
      .rst     (rst),
      .i_btn_n (btn[i]),
      .o_evt   (w_evt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RESET;
    else     r_state <= w_next;
  end

  // Only the highest-priority event is considered; pause is a no-op outside RUN/PAUSE.
  always_comb begin
    w_next = r_state;
    if (w_evt[BTN_STOP]) begin
      w_next = ST_STOP;
    end else if (w_evt[BTN_PAUSE]) begin
      if (r_state == ST_RUN)        w_next = ST_PAUSE;
      else if (r_state == ST_PAUSE) w_next = ST_RUN;
    end else if (w_evt[BTN_START]) begin
      w_next = ST_RUN;
    end else if (w_evt[BTN_RESET]) begin
      w_next = ST_RESET;
    end
  end

  // Advance only while staying inside RUN/PAUSE: the edges leaving and re-entering
  // STOP both hold, so a resumed count keeps its phase and no tick lands in STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (w_next == ST_RESET) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (is_counting(r_state) && is_counting(w_next)) begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
        r_tick  <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  always_comb begin
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    disp_hold = 1'b0;
    led       = LED_STOP;
    unique case (r_state)
      ST_RESET: begin cnt_clr = 1'b1; led = LED_RESET; end
      ST_RUN:   begin cnt_en  = 1'b1; led = LED_RUN;   end
      ST_PAUSE: begin cnt_en  = 1'b1; disp_hold = 1'b1; led = LED_PAUSE; end
      default:  led = LED_STOP;
    endcase
  end

  assign tick  = r_tick;
  assign state = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DB       = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'hF;
  logic       tick, cnt_en, cnt_clr, disp_hold;
  logic [3:0] led;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  int ncyc = 0;
  int tick_cnt = 0;
  int last_tick = 0;
  bit have_last = 1'b0;
  int gaps[$];

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .tick      (tick),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_hold (disp_hold),
    .led       (led),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Tick monitor: records spacing between consecutive ticks.
  always @(negedge clk) begin
    ncyc++;
    if (tick === 1'b1) begin
      tick_cnt++;
      if (have_last) gaps.push_back(ncyc - last_tick);
      last_tick = ncyc;
      have_last = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask);
    btn = ~mask;
    cyc(LAT + 2);
  endtask

  task automatic wait_tick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tick === 1'b1) begin
        found = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  initial begin
    bit found;
    bit seen;
    bit ok;
    int tc0;

    // Reset
    cyc(2);
    chk("rst_state", 32'(state), 32'd3);
    chk("rst_led", 32'(led), 32'h8);
    chk("rst_clr", 32'(cnt_clr), 32'd1);
    chk("rst_en", 32'(cnt_en), 32'd0);
    chk("rst_hold", 32'(disp_hold), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tick !== 1'b0) seen = 1'b1;
    end
    chk("reset_no_tick", 32'(seen), 32'd0);
    chk("reset_state_hold", 32'(state), 32'd3);

    // Start: holding does nothing, release acts
    press(4'b0100);
    chk("hold_no_event", 32'(state), 32'd3);
    btn = 4'hF;
    cyc(LAT);
    chk("start_not_yet", 32'(state), 32'd3);
    cyc(1);
    chk("start_state", 32'(state), 32'd1);
    chk("start_led", 32'(led), 32'h4);
    chk("start_en", 32'(cnt_en), 32'd1);
    chk("start_clr", 32'(cnt_clr), 32'd0);
    cyc(3);
    chk("start_tick_e3", 32'(tick), 32'd0);
    cyc(1);
    chk("start_tick_e4", 32'(tick), 32'd1);
    cyc(1);
    chk("start_tick_e5", 32'(tick), 32'd0);
    cyc(3);
    chk("start_tick_e8", 32'(tick), 32'd1);

    // Pause toggle, tick period undisturbed
    gaps.delete();
    press(4'b0010);
    btn = 4'hF;
    cyc(LAT);
    chk("pause_not_yet", 32'(state), 32'd1);
    cyc(1);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_hold", 32'(disp_hold), 32'd1);
    chk("pause_led", 32'(led), 32'h2);
    chk("pause_en", 32'(cnt_en), 32'd1);
    cyc(12);
    press(4'b0010);
    btn = 4'hF;
    cyc(LAT + 1);
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_hold", 32'(disp_hold), 32'd0);
    chk("resume_led", 32'(led), 32'h4);
    cyc(8);
    ok = 1'b1;
    foreach (gaps[i]) if (gaps[i] != TICK_DIV) ok = 1'b0;
    chk("pause_period_ok", 32'(ok), 32'd1);
    chk("pause_gap_count", 32'(gaps.size() >= 6), 32'd1);

    // Stop with prescaler at 2, then resume keeps phase
    press(4'b0001);
    wait_tick(found);
    chk("stop_sync_tick", 32'(found), 32'd1);
    cyc(6 - LAT);
    btn = 4'hF;
    cyc(LAT);
    chk("stop_not_yet", 32'(state), 32'd1);
    cyc(1);
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_led", 32'(led), 32'h1);
    chk("stop_en", 32'(cnt_en), 32'd0);
    tc0 = tick_cnt;
    cyc(10);
    press(4'b0100);
    btn = 4'hF;
    cyc(LAT + 1);
    chk("restart_state", 32'(state), 32'd1);
    chk("stop_no_ticks", 32'(tick_cnt), 32'(tc0));
    cyc(1);
    chk("phase_tick_e1", 32'(tick), 32'd0);
    cyc(1);
    chk("phase_tick_e2", 32'(tick), 32'd1);

    // Simultaneous stop + reset: stop wins
    press(4'b1001);
    btn = 4'hF;
    cyc(LAT + 1);
    chk("simul_state", 32'(state), 32'd0);
    chk("simul_led", 32'(led), 32'h1);
    chk("simul_clr", 32'(cnt_clr), 32'd0);

    // Reset button
    press(4'b1000);
    btn = 4'hF;
    cyc(LAT + 1);
    chk("btnrst_state", 32'(state), 32'd3);
    chk("btnrst_led", 32'(led), 32'h8);
    chk("btnrst_clr", 32'(cnt_clr), 32'd1);

    // Asynchronous rst mid-count
    press(4'b0100);
    btn = 4'hF;
    cyc(LAT + 1);
    chk("run_again", 32'(state), 32'd1);
    cyc(5);
    rst = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd3);
    chk("async_led", 32'(led), 32'h8);
    chk("async_en", 32'(cnt_en), 32'd0);
    chk("async_tick", 32'(tick), 32'd0);
    cyc(2);
    rst = 1'b0;

    // Pending event lost on rst
    press(4'b0001);
    btn = 4'hF;
    cyc(LAT);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(LAT + 3);
    chk("pending_lost", 32'(state), 32'd3);

`ifdef STOPWATCH_DEBOUNCE_EN
    // Glitch on a held button produces no event
    press(4'b0100);
    btn = 4'hF;
    cyc(2);
    btn = 4'b1011;
    cyc(12);
    chk("glitch_ignored", 32'(state), 32'd3);
    btn = 4'hF;
    cyc(LAT);
    chk("db_not_yet", 32'(state), 32'd3);
    cyc(1);
    chk("db_release", 32'(state), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
